// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM state encoding and bus widths.
package mem_bus_arbiter_pkg;

  localparam int unsigned REG_BUS_W = 32;
  localparam int unsigned SEL_W     = 4;
  localparam logic [SEL_W-1:0] SEL_WORD = 4'hF;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_FETCH = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-ported memory between fetch and data access; data has priority.
// Optional ack timeout with sticky bus error enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           stall_i,
  input  logic                 if_ce_i,
  input  logic [REG_BUS_W-1:0] if_addr_i,
  output logic [REG_BUS_W-1:0] if_data_o,
  output logic                 if_stallreq_o,
  input  logic                 d_ce_i,
  input  logic                 d_we_i,
  input  logic [SEL_W-1:0]     d_sel_i,
  input  logic [REG_BUS_W-1:0] d_addr_i,
  input  logic [REG_BUS_W-1:0] d_wdata_i,
  output logic [REG_BUS_W-1:0] d_data_o,
  output logic                 d_stallreq_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [SEL_W-1:0]     mem_sel_o,
  output logic [REG_BUS_W-1:0] mem_addr_o,
  output logic [REG_BUS_W-1:0] mem_wdata_o,
  input  logic [REG_BUS_W-1:0] mem_rdata_i,
  input  logic                 mem_ack_i,
  output logic                 bus_err_o
);

  arb_state_e           state_q, state_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [REG_BUS_W-1:0] addr_q, addr_d;
  logic [REG_BUS_W-1:0] wdata_q, wdata_d;
  logic [REG_BUS_W-1:0] if_data_q, if_data_d;
  logic [REG_BUS_W-1:0] d_data_q, d_data_d;
  logic                 if_done_q, if_done_d;
  logic                 d_done_q, d_done_d;
  logic                 bus_err_q, bus_err_d;

  logic unused_stall;
  assign unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if_data_d = if_data_q;
    d_data_d  = d_data_q;
    if_done_d = if_done_q;
    d_done_d  = d_done_q;
    bus_err_d = bus_err_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    // done marks "this pipeline slot already got its access"; it drops once the stage advances
    if (!if_ce_i || (if_done_q && !stall_i[1])) if_done_d = 1'b0;
    if (!d_ce_i  || (d_done_q  && !stall_i[4])) d_done_d  = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (d_ce_i && !d_done_q) begin
          state_d = ARB_DATA;
          req_d   = 1'b1;
          we_d    = d_we_i;
          sel_d   = d_sel_i;
          addr_d  = d_addr_i;
          wdata_d = d_wdata_i;
        end else if (if_ce_i && !if_done_q) begin
          state_d = ARB_FETCH;
          req_d   = 1'b1;
          we_d    = 1'b0;
          sel_d   = SEL_WORD;
          addr_d  = if_addr_i;
          wdata_d = '0;
        end
      end
      ARB_FETCH, ARB_DATA: begin
        if (mem_ack_i) begin
          state_d = ARB_IDLE;
          req_d   = 1'b0;
          if (state_q == ARB_FETCH) begin
            if_data_d = mem_rdata_i;
            if_done_d = 1'b1;
          end else begin
            if (!we_q) d_data_d = mem_rdata_i;
            d_done_d = 1'b1;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d   = ARB_IDLE;
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          if (state_q == ARB_FETCH) begin
            if_data_d = '0;
            if_done_d = 1'b1;
          end else begin
            if (!we_q) d_data_d = '0;
            d_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = ARB_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_data_q <= '0;
      d_data_q  <= '0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      bus_err_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      if_data_q <= if_data_d;
      d_data_q  <= d_data_d;
      if_done_q <= if_done_d;
      d_done_q  <= d_done_d;
      bus_err_q <= bus_err_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign if_stallreq_o = if_ce_i & ~if_done_q;
  assign d_stallreq_o  = d_ce_i & ~d_done_q;
  assign if_data_o     = if_data_q;
  assign d_data_o      = d_data_q;
  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_sel_o     = sel_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign bus_err_o     = bus_err_q;

endmodule
